// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR access unit.
// Counter addresses are only decoded when CSR_COUNTERS_EN is defined.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Low two bits of mtvec/mepc are hardwired to zero.
    localparam logic [31:0] MTVEC_WARL_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WARL_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } csr_state_t;

    typedef enum logic [1:0] {
        OP_RW = 2'd0,
        OP_RS = 2'd1,
        OP_RC = 2'd2
    } csr_op_t;

    function automatic csr_op_t funct3_to_op(input logic [1:0] f3_low);
        case (f3_low)
            2'b10:   return OP_RS;
            2'b11:   return OP_RC;
            default: return OP_RW;
        endcase
    endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// Combinational read-modify-write datapath: derives the new CSR value and
// whether the write actually happens for a given op, old value and source.
module csr_wdata_calc
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_t           i_op,
    input  logic [XLEN-1:0]   i_old,
    input  logic [XLEN-1:0]   i_src,
    input  logic              i_suppress,
    output logic [XLEN-1:0]   o_wdata,
    output logic              o_we
);

    // Set/clear with a zero source field are pure reads; plain writes never are.
    always_comb begin
        o_wdata = i_src;
        o_we    = 1'b1;
        case (i_op)
            OP_RW: begin
                o_wdata = i_src;
                o_we    = 1'b1;
            end
            OP_RS: begin
                o_wdata = i_old | i_src;
                o_we    = ~i_suppress;
            end
            OP_RC: begin
                o_wdata = i_old & ~i_src;
                o_we    = ~i_suppress;
            end
            default: begin
                o_wdata = i_src;
                o_we    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-stage Zicsr unit owning all machine CSRs; one request at a time.
// Define CSR_COUNTERS_EN to add mcycle/minstret and their read-only aliases.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [11:0]       req_addr,
    input  logic [XLEN-1:0]   req_rs1_val,
    input  logic [4:0]        req_zimm,
    input  logic              req_rs1_is_x0,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_illegal,
    input  logic              instret_pulse
);

    csr_state_t        r_state;
    csr_op_t           r_op;
    logic              r_f3_illegal;
    logic [11:0]       r_addr;
    logic [XLEN-1:0]   r_src;
    logic              r_src_zero;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_illegal;

    logic [XLEN-1:0]   r_mstatus;
    logic [XLEN-1:0]   r_mie;
    logic [XLEN-1:0]   r_mtvec;
    logic [XLEN-1:0]   r_mscratch;
    logic [XLEN-1:0]   r_mepc;
    logic [XLEN-1:0]   r_mcause;

    logic [XLEN-1:0]   w_src;
    logic              w_src_zero;
    logic [XLEN-1:0]   w_rdata;
    logic              w_addr_hit;
    logic              w_read_only;
    logic [XLEN-1:0]   w_wdata;
    logic              w_we;
    logic              w_illegal;
    logic              w_commit;

`ifdef CSR_COUNTERS_EN
    logic [63:0]       r_mcycle;
    logic [63:0]       r_minstret;
    logic              w_wr_mcycle_lo;
    logic              w_wr_mcycle_hi;
    logic              w_wr_minstret_lo;
    logic              w_wr_minstret_hi;
`else
    logic              w_unused_instret;
    assign w_unused_instret = instret_pulse;
`endif

    assign w_src      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_val;
    assign w_src_zero = req_funct3[2] ? (req_zimm == 5'd0) : req_rs1_is_x0;

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_illegal = r_rsp_illegal;

    // Read mux over the latched address; a miss marks the address unimplemented.
    always_comb begin
        w_rdata    = '0;
        w_addr_hit = 1'b1;
        case (r_addr)
            CSR_MSTATUS:   w_rdata = r_mstatus;
            CSR_MIE:       w_rdata = r_mie;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,
            CSR_CYCLE:     w_rdata = r_mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:    w_rdata = r_mcycle[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:   w_rdata = r_minstret[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:  w_rdata = r_minstret[63:32];
`endif
            default: begin
                w_rdata    = '0;
                w_addr_hit = 1'b0;
            end
        endcase
    end

    csr_wdata_calc #(
        .XLEN       (XLEN)
    ) u_wdata_calc (
        .i_op       (r_op),
        .i_old      (w_rdata),
        .i_src      (r_src),
        .i_suppress (r_src_zero),
        .o_wdata    (w_wdata),
        .o_we       (w_we)
    );

    assign w_read_only = (r_addr[11:10] == 2'b11);
    assign w_illegal   = r_f3_illegal || !w_addr_hit || (w_we && w_read_only);
    assign w_commit    = (r_state == ST_EXEC) && w_we && !w_illegal;

    // Request/response sequencing; all handshake outputs are registered here.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_RW;
            r_f3_illegal  <= 1'b0;
            r_addr        <= '0;
            r_src         <= '0;
            r_src_zero    <= 1'b0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op         <= funct3_to_op(req_funct3[1:0]);
                        r_f3_illegal <= (req_funct3[1:0] == 2'b00);
                        r_addr       <= req_addr;
                        r_src        <= w_src;
                        r_src_zero   <= w_src_zero;
                        r_req_ready  <= 1'b0;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_rdata   <= w_illegal ? '0 : w_rdata;
                    r_rsp_illegal <= w_illegal;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Machine CSR storage; WARL bits are cleared on the way in.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (w_commit) begin
            case (r_addr)
                CSR_MSTATUS:  r_mstatus  <= w_wdata;
                CSR_MIE:      r_mie      <= w_wdata;
                CSR_MTVEC:    r_mtvec    <= w_wdata & MTVEC_WARL_MASK;
                CSR_MSCRATCH: r_mscratch <= w_wdata;
                CSR_MEPC:     r_mepc     <= w_wdata & MEPC_WARL_MASK;
                CSR_MCAUSE:   r_mcause   <= w_wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    assign w_wr_mcycle_lo   = w_commit && (r_addr == CSR_MCYCLE);
    assign w_wr_mcycle_hi   = w_commit && (r_addr == CSR_MCYCLEH);
    assign w_wr_minstret_lo = w_commit && (r_addr == CSR_MINSTRET);
    assign w_wr_minstret_hi = w_commit && (r_addr == CSR_MINSTRETH);

    // A software write to either half replaces that edge's increment.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr_mcycle_lo) begin
                r_mcycle <= {r_mcycle[63:32], w_wdata};
            end else if (w_wr_mcycle_hi) begin
                r_mcycle <= {w_wdata, r_mcycle[31:0]};
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_wr_minstret_lo) begin
                r_minstret <= {r_minstret[63:32], w_wdata};
            end else if (w_wr_minstret_hi) begin
                r_minstret <= {w_wdata, r_minstret[31:0]};
            end else if (instret_pulse) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit: a vector table for the
// single-transaction behaviour plus hand sequences for stall, reset and counters.
module tb_csr_access_unit;
    import csr_pkg::*;

    typedef struct {
        logic [2:0]  funct3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        x0;
        logic [31:0] expData;
        logic        expIll;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_rs1_val = '0;
    logic [4:0]  req_zimm = '0;
    logic        req_rs1_is_x0 = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        instret_pulse = 1'b0;

    int nVec = 0;
    int nMis = 0;
    int cyc = 0;
    int rstCyc = 0;

    vec_t vecs[$];

    csr_access_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_rs1_val   (req_rs1_val),
        .req_zimm      (req_zimm),
        .req_rs1_is_x0 (req_rs1_is_x0),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_illegal   (rsp_illegal),
        .instret_pulse (instret_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                                input logic [4:0] z, input logic x, input logic [31:0] ed, input logic ei);
        vec_t v;
        v.funct3  = f3;
        v.addr    = a;
        v.rs1     = r;
        v.zimm    = z;
        v.x0      = x;
        v.expData = ed;
        v.expIll  = ei;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; returns the accept edge number.
    task automatic applyStimulus(input string tag, input vec_t v, output int acc,
                                 output logic [31:0] data, output logic ill);
        int waited;
        @(negedge clk);
        req_funct3    = v.funct3;
        req_addr      = v.addr;
        req_rs1_val   = v.rs1;
        req_zimm      = v.zimm;
        req_rs1_is_x0 = v.x0;
        req_valid     = 1'b1;
        rsp_ready     = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " latency"}, 32'(waited), 32'd1);
        data = rsp_rdata;
        ill  = rsp_illegal;
        @(negedge clk);
        checkOutput({tag, " release rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, " release req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic runVec(input string tag, input vec_t v, output int acc, output logic [31:0] data);
        logic ill;
        applyStimulus(tag, v, acc, data, ill);
        checkOutput({tag, " illegal"}, {31'd0, ill}, {31'd0, v.expIll});
    endtask

    initial begin
        int acc;
        int accW;
        int acc2;
        logic [31:0] d;
        logic ill;
        logic [63:0] m;
        logic [63:0] v2;

        vecs.push_back(mk(F3_CSRRW,  CSR_MSCRATCH, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MSCRATCH, 32'hFFFFFFFF, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MSCRATCH, 32'h0000_0000, 5'd0, 1'b1, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  CSR_MIE,      32'h0000_0080, 5'd0, 1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRSI, CSR_MIE,      32'hFFFFFFFF, 5'h0A, 1'b0, 32'h0000_0080, 1'b0));
        vecs.push_back(mk(F3_CSRRCI, CSR_MIE,      32'hFFFFFFFF, 5'h02, 1'b0, 32'h0000_008A, 1'b0));
        vecs.push_back(mk(F3_CSRRSI, CSR_MIE,      32'hFFFFFFFF, 5'h00, 1'b0, 32'h0000_0088, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MIE,      32'h0000_0000, 5'd0, 1'b1, 32'h0000_0088, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  CSR_MTVEC,    32'h0000_1003, 5'd0, 1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MTVEC,    32'h0000_0000, 5'd0, 1'b1, 32'h0000_1000, 1'b0));
        vecs.push_back(mk(F3_CSRRWI, CSR_MTVEC,    32'h0000_0000, 5'h03, 1'b0, 32'h0000_1000, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MTVEC,    32'h0000_0000, 5'd0, 1'b1, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  12'h7FF,      32'h0000_0001, 5'd0, 1'b0, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(F3_CSRRS,  12'h301,      32'h0000_0000, 5'd0, 1'b1, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(3'b000,    CSR_MSCRATCH, 32'h0000_1234, 5'd0, 1'b0, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(3'b100,    CSR_MSCRATCH, 32'h0000_1234, 5'h05, 1'b0, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(F3_CSRRS,  CSR_MSCRATCH, 32'h0000_0000, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  CSR_MEPC,     32'hFFFFFFFF, 5'd0,  1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRC,  CSR_MEPC,     32'h0000_000F, 5'd0, 1'b0, 32'hFFFFFFFC, 1'b0));
        vecs.push_back(mk(F3_CSRRWI, CSR_MEPC,     32'h0000_0000, 5'h1F, 1'b0, 32'hFFFFFFF0, 1'b0));
        vecs.push_back(mk(F3_CSRRCI, CSR_MEPC,     32'h0000_0000, 5'h00, 1'b0, 32'h0000_001C, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MEPC,     32'h0000_0000, 5'd0, 1'b1, 32'h0000_001C, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  CSR_MCAUSE,   32'h8000_000B, 5'd0, 1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MCAUSE,   32'h0000_0001, 5'd0, 1'b0, 32'h8000_000B, 1'b0));
        vecs.push_back(mk(F3_CSRRCI, CSR_MCAUSE,   32'h0000_0000, 5'h01, 1'b0, 32'h8000_000B, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MCAUSE,   32'h0000_0000, 5'd0, 1'b1, 32'h8000_000A, 1'b0));
        vecs.push_back(mk(F3_CSRRW,  CSR_MSTATUS,  32'h0000_1888, 5'd0, 1'b0, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(F3_CSRRC,  CSR_MSTATUS,  32'h0000_0008, 5'd0, 1'b0, 32'h0000_1888, 1'b0));
        vecs.push_back(mk(F3_CSRRS,  CSR_MSTATUS,  32'h0000_0000, 5'd0, 1'b1, 32'h0000_1880, 1'b0));

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready",   {31'd0, req_ready},   32'd1);
        checkOutput("reset rsp_valid",   {31'd0, rsp_valid},   32'd0);
        checkOutput("reset rsp_rdata",   rsp_rdata,            32'd0);
        checkOutput("reset rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        nreset = 1'b1;
        rstCyc = cyc;

        foreach (vecs[i]) begin
            runVec($sformatf("v%0d", i), vecs[i], acc, d);
            checkOutput($sformatf("v%0d rdata", i), d, vecs[i].expData);
        end

        // Stalled response: outputs frozen while rsp_ready is low
        @(negedge clk);
        req_funct3 = F3_CSRRS; req_addr = CSR_MSCRATCH; req_rs1_val = 32'h5555_5555;
        req_zimm = 5'd0; req_rs1_is_x0 = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("stall rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("stall%0d rsp_rdata", k), rsp_rdata, 32'hDEADBEEF);
            checkOutput($sformatf("stall%0d rsp_illegal", k), {31'd0, rsp_illegal}, 32'd0);
            checkOutput($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall done rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("stall done req_ready", {31'd0, req_ready}, 32'd1);

        // Reset during EXEC drops the transaction and its write
        @(negedge clk);
        req_funct3 = F3_CSRRW; req_addr = CSR_MEPC; req_rs1_val = 32'h1234_5678;
        req_rs1_is_x0 = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        nreset = 1'b0;
        #1;
        checkOutput("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midrst req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        nreset = 1'b1;
        rstCyc = cyc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst%0d no response", k), {31'd0, rsp_valid}, 32'd0);
        end
        runVec("midrst mepc", mk(F3_CSRRS, CSR_MEPC, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        checkOutput("midrst mepc rdata", d, 32'd0);

`ifdef CSR_COUNTERS_EN
        // mcycle low-half write, wrap into the high half
        runVec("mcyc wr", mk(F3_CSRRW, CSR_MCYCLE, 32'hFFFFFFFF, 5'd0, 1'b0, 32'd0, 1'b0), accW, d);
        checkOutput("mcyc wr rdata", d, 32'(accW - rstCyc));
        repeat (3) @(negedge clk);
        runVec("mcycleh rd", mk(F3_CSRRS, CSR_MCYCLEH, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        m = 64'h0000_0000_FFFF_FFFF + 64'(acc - accW - 1);
        checkOutput("mcycleh rd rdata", d, m[63:32]);
        checkOutput("mcycleh wrapped", d, 32'd1);
        runVec("mcycle rd", mk(F3_CSRRS, CSR_MCYCLE, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        m = 64'h0000_0000_FFFF_FFFF + 64'(acc - accW - 1);
        checkOutput("mcycle rd rdata", d, m[31:0]);
        runVec("cycle wr", mk(F3_CSRRW, CSR_CYCLE, 32'd5, 5'd0, 1'b0, 32'd0, 1'b1), acc, d);
        checkOutput("cycle wr rdata", d, 32'd0);
        runVec("cycle rd", mk(F3_CSRRS, CSR_CYCLE, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        m = 64'h0000_0000_FFFF_FFFF + 64'(acc - accW - 1);
        checkOutput("cycle rd rdata", d, m[31:0]);

        // High-half write holds the low half for that edge
        runVec("mcycleh wr", mk(F3_CSRRW, CSR_MCYCLEH, 32'd7, 5'd0, 1'b0, 32'd0, 1'b0), acc2, d);
        v2 = 64'h0000_0000_FFFF_FFFF + 64'(acc2 - accW - 1);
        checkOutput("mcycleh wr rdata", d, v2[63:32]);
        runVec("mcycle hold", mk(F3_CSRRS, CSR_MCYCLE, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        m = {32'd7, v2[31:0]} + 64'(acc - acc2 - 1);
        checkOutput("mcycle hold rdata", d, m[31:0]);
        runVec("cycleh rd", mk(F3_CSRRS, CSR_CYCLEH, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        checkOutput("cycleh rd rdata", d, 32'd7);

        // minstret counts only retire pulses
        runVec("minstret rd0", mk(F3_CSRRS, CSR_MINSTRET, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        checkOutput("minstret rd0 rdata", d, 32'd0);
        @(negedge clk);
        instret_pulse = 1'b1;
        repeat (3) @(negedge clk);
        instret_pulse = 1'b0;
        runVec("instret rd", mk(F3_CSRRS, CSR_INSTRET, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        checkOutput("instret rd rdata", d, 32'd3);
        runVec("instreth rd", mk(F3_CSRRS, CSR_INSTRETH, 32'd0, 5'd0, 1'b1, 32'd0, 1'b0), acc, d);
        checkOutput("instreth rd rdata", d, 32'd0);
        runVec("instret rs nz", mk(F3_CSRRS, CSR_INSTRET, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1), acc, d);
        checkOutput("instret rs nz rdata", d, 32'd0);
`else
        runVec("mcycle off", mk(F3_CSRRS, CSR_MCYCLE, 32'd0, 5'd0, 1'b1, 32'd0, 1'b1), acc, d);
        checkOutput("mcycle off rdata", d, 32'd0);
        runVec("cycle off", mk(F3_CSRRS, CSR_CYCLE, 32'd0, 5'd0, 1'b1, 32'd0, 1'b1), acc, d);
        checkOutput("cycle off rdata", d, 32'd0);
        runVec("mcycleh off", mk(F3_CSRRW, CSR_MCYCLEH, 32'd9, 5'd0, 1'b0, 32'd0, 1'b1), acc, d);
        checkOutput("mcycleh off rdata", d, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
